// File: rtl/penc_drain_seq_if.sv
// Request-vector / index-stream handshake bundle for penc_drain_seq.
// slave: the encoder side; master: the producer/consumer side.
interface penc_drain_seq_if #(
  parameter int unsigned NBITS = 16
);
  localparam int unsigned IDXW = $clog2(NBITS);

  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_;
  logic             out_val;
  logic             out_rdy;
  logic [IDXW-1:0]  out;
  logic             out_last;

  modport slave (
    input  in_val,
    input  in_,
    input  out_rdy,
    output in_rdy,
    output out_val,
    output out,
    output out_last
  );

  modport master (
    output in_val,
    output in_,
    output out_rdy,
    input  in_rdy,
    input  out_val,
    input  out,
    input  out_last
  );
endinterface

// File: rtl/penc_drain_seq.sv
// Sequential priority encoder: drains an NBITS request mask as a priority-ordered index stream.
// Define PENC_DRAIN_SEQ_COUNT_EN to add the registered pending_cnt popcount output.
module penc_drain_seq #(
  parameter int unsigned NBITS    = 16,
  parameter int unsigned MSB_PRIO = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  penc_drain_seq_if.slave              bus
`ifdef PENC_DRAIN_SEQ_COUNT_EN
  ,
  output logic [$clog2(NBITS+1)-1:0]   pending_cnt
`endif
);

  localparam int unsigned IDXW = $clog2(NBITS);
  localparam int unsigned CNTW = $clog2(NBITS + 1);
  localparam logic [NBITS-1:0] LSB1 = {{(NBITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] pending_q, pending_d;
  logic [IDXW-1:0]  head_idx;
  logic             head_last;
  logic             in_fire;
  logic             out_fire;
  logic             in_nz;

  // Later matches overwrite earlier ones, so scan toward the highest-priority end.
  function automatic logic [IDXW-1:0] prio_idx(input logic [NBITS-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    if (MSB_PRIO != 0) begin
      for (int unsigned i = 0; i < NBITS; i++) begin
        if (v[i]) idx = IDXW'(i);
      end
    end else begin
      for (int unsigned i = NBITS; i > 0; i--) begin
        if (v[i-1]) idx = IDXW'(i - 1);
      end
    end
    return idx;
  endfunction

  always_comb begin
    head_idx  = prio_idx(pending_q);
    head_last = (pending_q != '0) && ((pending_q & (pending_q - LSB1)) == '0);
    in_nz     = (bus.in_ != '0);
  end

  // in_rdy is gated by the raw reset input so it stays low for the whole reset pulse,
  // and in DRAIN it follows out_rdy combinationally to allow bubble-free reload.
  always_comb begin
    bus.out_val  = (state_q == DRAIN);
    bus.out      = (state_q == DRAIN) ? head_idx : '0;
    bus.out_last = (state_q == DRAIN) && head_last;
    bus.in_rdy   = reset && ((state_q == IDLE) ||
                             ((state_q == DRAIN) && head_last && bus.out_rdy));
    out_fire     = bus.out_val && bus.out_rdy;
    in_fire      = bus.in_val && bus.in_rdy;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (out_fire) begin
      pending_d = pending_q & ~(LSB1 << head_idx);
      if (head_last) state_d = IDLE;
    end
    if (in_fire) begin
      pending_d = bus.in_;
      state_d   = in_nz ? DRAIN : IDLE;
    end
  end

`ifdef PENC_DRAIN_SEQ_COUNT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  function automatic logic [CNTW-1:0] popcount(input logic [NBITS-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      n = n + CNTW'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire) begin
      cnt_d = popcount(bus.in_);
    end else if (out_fire) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  assign pending_cnt = cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
`ifdef PENC_DRAIN_SEQ_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
`ifdef PENC_DRAIN_SEQ_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
